// File: rtl/cache_flush_pkg.sv
// Shared types and constants for the cache flush sequencer.
// Imported by cache_flush_seq and its bench.
package cache_flush_pkg;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    CHECK,
    WB,
    NEXT,
    DONE
  } flush_state_t;

  localparam int CLEAN_SET_CYCLES = 3;

endpackage

// File: rtl/cache_flush_seq_priorityonehot.sv
// Priority one-hot selector: keeps only the lowest set bit of a.
// Used to pick the next dirty way under writeback.
module priorityonehot #(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  output logic [N-1:0] y
);

  assign y = a & (~a + N'(1));

endmodule

// File: rtl/cache_flush_seq.sv
// Full-cache flush sequencer: walks sets, writes back dirty ways.
// Build option FLUSH_INVALIDATE_EN also invalidates each walked set.
module cache_flush_seq
  import cache_flush_pkg::*;
#(
  parameter int NUMWAYS  = 4,
  parameter int SETLEN   = 9,
  parameter int NUMLINES = 128
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               FlushStart,
  input  logic [NUMWAYS-1:0] DirtyWay,
  input  logic               WbAck,
  output logic [SETLEN-1:0]  FlushAdr,
  output logic [NUMWAYS-1:0] FlushWay,
  output logic               ArrayRdEn,
  output logic               WbReq,
  output logic               ClearDirty,
  output logic               ClearValid,
  output logic               FlushBusy,
  output logic               FlushDone
);

  localparam int CW = $clog2(NUMLINES) + 1;

  flush_state_t       r_state;
  flush_state_t       w_next;
  logic [CW-1:0]      r_setcnt;
  logic [NUMWAYS-1:0] r_pending;
  logic [NUMWAYS-1:0] w_way;
  logic [NUMWAYS-1:0] w_pend_nxt;
  logic               w_last;

  priorityonehot #(.N(NUMWAYS)) u_pri (
    .a (r_pending),
    .y (w_way)
  );

  assign w_last     = (r_setcnt == CW'(NUMLINES - 1));
  assign w_pend_nxt = r_pending & ~w_way;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_setcnt  <= '0;
      r_pending <= '0;
    end else begin
      r_state <= w_next;
      unique case (r_state)
        IDLE:  if (FlushStart) r_setcnt <= '0;
        CHECK: r_pending <= DirtyWay;
        WB:    if (WbAck) r_pending <= w_pend_nxt;
        NEXT:  if (!w_last) r_setcnt <= r_setcnt + 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next     = r_state;
    ArrayRdEn  = 1'b0;
    WbReq      = 1'b0;
    ClearDirty = 1'b0;
    ClearValid = 1'b0;
    FlushWay   = '0;
    unique case (r_state)
      IDLE: begin
        if (FlushStart) w_next = READ;
      end
      READ: begin
        ArrayRdEn = 1'b1;
        w_next    = CHECK;
      end
      CHECK: begin
        w_next = (DirtyWay == '0) ? NEXT : WB;
      end
      WB: begin
        FlushWay = w_way;
        WbReq    = 1'b1;
        if (WbAck) begin
          ClearDirty = 1'b1;
          if (w_pend_nxt == '0) w_next = NEXT;
        end
      end
      NEXT: begin
`ifdef FLUSH_INVALIDATE_EN
        ClearValid = 1'b1;
        FlushWay   = '1;
`endif
        w_next = w_last ? DONE : READ;
      end
      DONE: begin
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  assign FlushAdr  = SETLEN'(r_setcnt);
  assign FlushBusy = (r_state != IDLE);
  assign FlushDone = (r_state == DONE);

endmodule
